// File: rtl/game_pkg.sv
// Shared board types and constants for the game-state datapath.
package game_pkg;

    localparam int unsigned TILE_W    = 12;
    localparam int unsigned GRID_N    = 4;
    localparam int unsigned WIN_VALUE = 2048;

    localparam int unsigned IDX_W = $clog2(GRID_N);
    // Must hold GRID_N*GRID_N itself, not just GRID_N*GRID_N-1.
    localparam int unsigned CNT_W = $clog2(GRID_N * GRID_N + 1);

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [GRID_N-1:0][GRID_N-1:0] board_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

    localparam tile_t WIN_TILE = tile_t'(WIN_VALUE);

endpackage

// File: rtl/tile_stats_acc.sv
// Running empty-cell count and unsigned maximum over a stream of tiles.
module tile_stats_acc
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [TILE_W-1:0] tile,
    output logic [CNT_W-1:0]  count,
    output logic [TILE_W-1:0] max_val
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            max_val <= '0;
        end else if (clear) begin
            count   <= '0;
            max_val <= '0;
        end else if (en) begin
            if (tile == '0) begin
                count <= count + cnt_t'(1);
            end
            if (tile > max_val) begin
                max_val <= tile;
            end
        end
    end

endmodule

// File: rtl/matrix_scanner.sv
// Snapshots the board on start and streams its tiles row-major over valid/ready,
// publishing empty count, max tile and win once the last tile is accepted.
module matrix_scanner
    import game_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [GRID_N-1:0][GRID_N-1:0][TILE_W-1:0] matrix_in,
    output logic                                   tile_valid,
    input  logic                                   tile_ready,
    output logic [TILE_W-1:0]                      tile_value,
    output logic [IDX_W-1:0]                       tile_row,
    output logic [IDX_W-1:0]                       tile_col,
    output logic                                   tile_last,
    output logic                                   busy,
    output logic                                   done,
    output logic [CNT_W-1:0]                       empty_count,
    output logic [TILE_W-1:0]                      max_tile,
    output logic                                   win
);

    scan_state_t state_q;
    board_t      snap_q;
    idx_t        row_q;
    idx_t        col_q;
    cnt_t        empty_hold_q;
    tile_t       max_hold_q;

    cnt_t  run_count;
    tile_t run_max;
    logic  acc_clear;
    logic  handshake;

    assign tile_valid = (state_q == SCAN);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign tile_row   = row_q;
    assign tile_col   = col_q;
    assign tile_value = tile_valid ? snap_q[row_q][col_q] : '0;
    assign tile_last  = tile_valid && (row_q == idx_t'(GRID_N - 1))
                                   && (col_q == idx_t'(GRID_N - 1));
    assign handshake  = tile_valid && tile_ready;
    assign acc_clear  = (state_q == IDLE) && start;

    // In DONE the accumulator already includes the last tile, so the stats are
    // shown straight from it and latched for display until the next scan ends.
    assign empty_count = done ? run_count : empty_hold_q;
    assign max_tile    = done ? run_max : max_hold_q;
    assign win         = (max_tile == WIN_TILE);

    tile_stats_acc u_stats (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .en      (handshake),
        .tile    (tile_value),
        .count   (run_count),
        .max_val (run_max)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            row_q        <= '0;
            col_q        <= '0;
            empty_hold_q <= '0;
            max_hold_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q  <= matrix_in;
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (tile_ready) begin
                        if (col_q == idx_t'(GRID_N - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + idx_t'(1);
                        end else begin
                            col_q <= col_q + idx_t'(1);
                        end
                        if (tile_last) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    empty_hold_q <= run_count;
                    max_hold_q   <= run_max;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scanner.sv
// Directed and randomized scans of matrix_scanner against a board-level model.
module tb_matrix_scanner;
    import game_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    board_t       matrix_in = '0;
    logic         tile_valid;
    logic         tile_ready = 1'b0;
    tile_t        tile_value;
    idx_t         tile_row;
    idx_t         tile_col;
    logic         tile_last;
    logic         busy;
    logic         done;
    cnt_t         empty_count;
    tile_t        max_tile;
    logic         win;

    int vectors = 0;
    int miscompares = 0;

    // Statistics the DUT should be showing outside of a DONE cycle.
    int prev_empty = 0;
    int prev_max = 0;
    int prev_win = 0;

    always #5 clk = ~clk;

    matrix_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matrix_in   (matrix_in),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .tile_value  (tile_value),
        .tile_row    (tile_row),
        .tile_col    (tile_col),
        .tile_last   (tile_last),
        .busy        (busy),
        .done        (done),
        .empty_count (empty_count),
        .max_tile    (max_tile),
        .win         (win)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_empty(input board_t b);
        int n = 0;
        for (int i = 0; i < GRID_N * GRID_N; i++) begin
            if (b[i / GRID_N][i % GRID_N] == 0) n++;
        end
        return n;
    endfunction

    function automatic int model_max(input board_t b);
        int m = 0;
        for (int i = 0; i < GRID_N * GRID_N; i++) begin
            if (int'(b[i / GRID_N][i % GRID_N]) > m) m = int'(b[i / GRID_N][i % GRID_N]);
        end
        return m;
    endfunction

    function automatic board_t rand_board();
        board_t b;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                case ($urandom_range(0, 3))
                    0:       b[r][c] = '0;
                    1:       b[r][c] = tile_t'(1) << $urandom_range(1, 11);
                    default: b[r][c] = tile_t'($urandom_range(0, 4095));
                endcase
            end
        end
        return b;
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_valid"}, int'(tile_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_empty"}, int'(empty_count), 0);
        check({tag, "_max"}, int'(max_tile), 0);
        check({tag, "_win"}, int'(win), 0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: 3-cycle stall on tile (1,2).
    task automatic run_scan(input board_t board, input int mode, input bit noise,
                            input bit mutate);
        int n = 0;
        int cyc = 0;
        int valid_cycles = 0;
        int stall = 0;
        bit finished = 0;
        int exp_e = model_empty(board);
        int exp_m = model_max(board);
        int exp_w = (exp_m == int'(WIN_VALUE)) ? 1 : 0;
        @(negedge clk);
        matrix_in = board;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("first_valid", int'(tile_valid), 1);
        while (!finished && cyc < 300) begin
            cyc++;
            if (tile_valid) begin
                valid_cycles++;
                check("tile_value", int'(tile_value), int'(board[n / GRID_N][n % GRID_N]));
                check("tile_row", int'(tile_row), n / GRID_N);
                check("tile_col", int'(tile_col), n % GRID_N);
                check("tile_last", int'(tile_last), (n == GRID_N * GRID_N - 1) ? 1 : 0);
                check("scan_done", int'(done), 0);
                check("scan_busy", int'(busy), 1);
                check("held_empty", int'(empty_count), prev_empty);
                check("held_max", int'(max_tile), prev_max);
                check("held_win", int'(win), prev_win);
            end else begin
                check("done_pulse", int'(done), 1);
                check("done_busy", int'(busy), 1);
                check("handshakes", n, GRID_N * GRID_N);
                check("empty_count", int'(empty_count), exp_e);
                check("max_tile", int'(max_tile), exp_m);
                check("win", int'(win), exp_w);
                if (mode == 0) check("full_speed_len", valid_cycles, GRID_N * GRID_N);
                prev_empty = exp_e;
                prev_max = exp_m;
                prev_win = exp_w;
                finished = 1;
            end
            if (mutate) matrix_in = rand_board();
            if (mode == 0) begin
                tile_ready = 1'b1;
            end else if (mode == 2 && n == 6 && stall < 3) begin
                tile_ready = 1'b0;
                stall++;
            end else if (mode == 2) begin
                tile_ready = 1'b1;
            end else begin
                tile_ready = 1'($urandom_range(0, 1));
            end
            start = noise ? 1'b1 : 1'b0;
            if (tile_valid && tile_ready) n++;
            @(negedge clk);
        end
        check("scan_finished", int'(finished), 1);
        check("post_busy", int'(busy), 0);
        check("post_done", int'(done), 0);
        check("post_valid", int'(tile_valid), 0);
        check("post_empty", int'(empty_count), prev_empty);
        check("post_max", int'(max_tile), prev_max);
        check("post_win", int'(win), prev_win);
        start = 1'b0;
    endtask

    initial begin
        board_t b;

        // Reset state.
        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("after_reset");

        // Full-speed ramp board.
        for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++) b[r][c] = tile_t'(GRID_N * r + c);
        run_scan(b, 0, 1'b0, 1'b0);

        // Backpressure on tile (1,2), with start noise during the scan and DONE.
        run_scan(rand_board(), 2, 1'b1, 1'b0);

        // Snapshot isolation.
        run_scan(rand_board(), 1, 1'b0, 1'b1);

        // Win board, then all-zero board.
        b = '0;
        b[GRID_N-1][GRID_N-1] = WIN_TILE;
        run_scan(b, 0, 1'b0, 1'b0);
        run_scan('0, 1, 1'b0, 1'b0);

        // Larger-than-win tile: max is unsigned, win needs equality.
        b = rand_board();
        b[2][1] = WIN_TILE;
        b[0][3] = tile_t'(4095);
        run_scan(b, 1, 1'b1, 1'b0);

        // Abort at tile 7.
        for (int r = 0; r < GRID_N; r++)
            for (int c = 0; c < GRID_N; c++) b[r][c] = tile_t'(GRID_N * r + c + 1);
        @(negedge clk);
        matrix_in = b;
        tile_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_at_tile7", int'(tile_value), 8);
        rst = 1'b0;
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        rst = 1'b1;
        prev_empty = 0;
        prev_max = 0;
        prev_win = 0;
        @(negedge clk);
        check_idle_zero("post_abort");
        run_scan(b, 0, 1'b0, 1'b0);

        // Randomized scans.
        for (int i = 0; i < 8; i++) begin
            run_scan(rand_board(), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
Name: matrix_scanner

Overview:
- Reader side of the game-state register: takes a snapshot of the registered 4x4 tile matrix on request.
- Streams the 16 tiles one at a time, row-major, over a valid/ready handshake to the renderer/display path.
- Accumulates board statistics while streaming: empty-cell count, maximum tile, win flag.
- Sits between the current-state register output and the display/score logic.

Parameters:
- TILE_W, 12, bit width of one tile value.
- GRID_N, 4, rows/columns of the square board (row/col index width = $clog2(GRID_N)).
- WIN_VALUE, 2048, tile value that raises win.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request a scan; sampled only in IDLE.
- matrix_in  input  TILE_W x GRID_N x GRID_N  current board, indexed [row][col].
- tile_valid  output  1  tile_value/tile_row/tile_col/tile_last are valid.
- tile_ready  input  1  consumer accepts the presented tile.
- tile_value  output  TILE_W  value of the presented tile.
- tile_row  output  2  row index of the presented tile.
- tile_col  output  2  column index of the presented tile.
- tile_last  output  1  presented tile is (3,3).
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse at scan completion.
- empty_count  output  5  number of zero tiles from the last completed scan (0..16).
- max_tile  output  TILE_W  largest tile from the last completed scan.
- win  output  1  max_tile == WIN_VALUE from the last completed scan.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, snapshot cleared, row/col counters 0, accumulators 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge k: copy matrix_in into the internal snapshot, clear the accumulators, row=col=0, go SCAN.
  - tile_valid is first high in cycle k+1, which is registered latency 1.
  - Later changes to matrix_in do not affect the scan in progress.
- SCAN:
  - tile_valid=1. tile_value = snapshot[row][col]; tile_last = (row==3 && col==3).
  - While tile_ready=0, all tile_* outputs hold stable and nothing advances.
  - On each handshake (tile_valid && tile_ready):
    - Update the running accumulators: running count +1 if the tile is 0; running max = max(running max, tile).
    - Advance col; on col wrap 3->0, advance row.
    - If tile_last, go DONE.
  - Minimum scan length is 16 cycles with tile_ready held high.
- DONE (exactly 1 cycle):
  - tile_valid=0, done=1.
  - empty_count, max_tile and win are updated from the final running values, including the last tile.
  - Go IDLE.
- Statistic outputs change only on entry to DONE; they hold the previous scan's values until then. They read 0 after reset until the first completed scan.
- busy = (state != IDLE).
- start while busy is ignored; it is not queued. start arriving in the same cycle as done is also ignored.
- Reset mid-scan aborts immediately with no done pulse, and every output returns to its reset value.
- The max comparison is unsigned over TILE_W bits. empty_count saturates naturally at 16 and cannot overflow 5 bits.

Decomposition:
- game_pkg holds:
  - TILE_W, GRID_N, WIN_VALUE constants.
  - typedef tile_t (logic [TILE_W-1:0]).
  - typedef board_t (tile_t [GRID_N-1:0][GRID_N-1:0]).
  - enum scan_state_t {IDLE, SCAN, DONE}.
- One sub-module, tile_stats_acc: clear/enable/tile inputs -> running empty count and running max. It is registered and reusable by the scoring logic.

Test Plan:
- Reset: rst=0 mid-operation -> tile_valid=0, busy=0, done=0, empty_count=0, max_tile=0, win=0 within the same cycle (async).
- Full-speed scan: board with tile[r][c] = 4*r+c, tile_ready=1, start pulse -> 16 consecutive tiles 0..15 in row-major order, tile_last only on the 16th, done 1 cycle after the last, empty_count=1, max_tile=15, win=0.
- Backpressure: tile_ready low for 3 cycles while tile (1,2) is presented -> tile_value/tile_row/tile_col stable throughout, no tile skipped or repeated, total handshakes = 16.
- Snapshot: start, then change matrix_in every cycle during the scan -> streamed values equal the board at the start edge.
- Win/empty: board all zeros except one 2048 at (3,3) -> empty_count=15, max_tile=2048, win=1 after done. A following scan of an all-zero board -> empty_count=16, max_tile=0, win=0.
- Abort/ignore: start asserted during SCAN -> no restart. rst pulsed at tile 7 -> no done pulse. A new start after reset -> scan begins at (0,0) with fresh statistics.
